// File: rtl/uart_wb_cmd_master_if.sv
// Command/response stream and Wishbone master bus of uart_wb_cmd_master.
// master = the command master block itself, slave = the environment around it.
interface uart_wb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [4:0]  cmd_addr;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [4:0]  wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    logic        busy;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_wdata, rsp_ready, wb_ack_i, wb_dat_i,
        output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
               wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_wdata, rsp_ready, wb_ack_i, wb_dat_i,
        input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
               wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy
    );
endinterface

// File: rtl/uart_wb_cmd_master.sv
// Wishbone classic master feeding the UART register port from a small command FIFO.
// Optional macro WBM_TIMEOUT_EN aborts a cycle after TIMEOUT_CYCLES without ack.
module uart_wb_cmd_master #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    uart_wb_cmd_master_if.master        bus
);
    localparam int AW = $clog2(CMD_DEPTH);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        mem [CMD_DEPTH];
    cmd_t        head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;

    logic [1:0]  state;
    logic [4:0]  addr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q, cyc_q;
    logic        rsp_valid_q, rsp_we_q, err_q;
    logic [31:0] rsp_rdata_q;
    logic        tmo_hit;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state == IDLE) && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_sel, bus.cmd_wdata};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    // Counts REQ cycles without ack; reads zero whenever the FSM is outside REQ.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                tmo_cnt <= '0;
        else if (state != REQ)       tmo_cnt <= '0;
        else if (!bus.wb_ack_i)      tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Ack on the expiry edge wins over the abort.
    assign tmo_hit = (state == REQ) && !bus.wb_ack_i && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        addr_q <= head.addr;
                        dat_q  <= head.wdata;
                        sel_q  <= head.sel;
                        we_q   <= head.we;
                        cyc_q  <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (bus.wb_ack_i || tmo_hit) begin
                        cyc_q       <= 1'b0;
                        dat_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= we_q;
                        rsp_rdata_q <= (bus.wb_ack_i && !we_q) ? bus.wb_dat_i : 32'd0;
                        err_q       <= tmo_hit;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.wb_addr_o = addr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = cyc_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state != IDLE) || !empty;
endmodule

// File: tb/tb_uart_wb_cmd_master.sv
// Bench for uart_wb_cmd_master: directed table, multi-cycle corner sequences and random traffic
// checked against queue-based command/response scoreboards and a reactive Wishbone slave.
module tb_uart_wb_cmd_master;
    localparam int TMO = 8;

    typedef struct { logic we; logic [4:0] addr; logic [3:0] sel; logic [31:0] wdata; } cmd_t;
    typedef struct { logic we; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { cmd_t c; int dly; logic [31:0] sdata; logic [31:0] exp_rdata; int exp_width; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_wb_cmd_master_if bus();

    uart_wb_cmd_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0, n_fail = 0, n_rsp = 0, cyc_seen = 0, last_width = 0;
    int   ack_dly = 0, rdy_mode = 0, req_cnt = 0;
    logic ack_hold = 1'b0, slv_rand = 1'b0, stray_en = 1'b0;
    logic rsp_seen = 1'b0, inflight = 1'b0, ending = 1'b0;
    logic [31:0] slv_data = '0, d;
    cmd_t cmd_q[$];
    rsp_t exp_q[$];
    rsp_t last_rsp, cur_rsp, exp_r;
    cmd_t sh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        logic [31:0] r;
        r = $urandom;
        c.we = r[0]; c.addr = r[5:1]; c.sel = r[9:6]; c.wdata = $urandom;
        return c;
    endfunction

    task automatic push(input cmd_t c);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = c.we;
        bus.cmd_addr  = c.addr;
        bus.cmd_sel   = c.sel;
        bus.cmd_wdata = c.wdata;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 64'(bus.cmd_ready), 64'(1));
        if (bus.cmd_ready) cmd_q.push_back(c);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int n = 0;
        while (n_rsp < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(n_rsp), 64'(target));
    endtask

    // Wishbone slave: acks after ack_dly cycles of stb, checks bus fields against the push order.
    initial begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = $urandom;
            if (rst) begin
                inflight = 1'b0;
                ending   = 1'b0;
                continue;
            end
            if (ending) begin
                chk("wb_cyc_drop", 64'({bus.wb_cyc_o, bus.wb_stb_o}), 64'(0));
                ending   = 1'b0;
                inflight = 1'b0;
            end else if (bus.wb_cyc_o) begin
                if (!inflight) begin
                    inflight = 1'b1;
                    req_cnt  = 0;
                    cyc_seen++;
                    if (slv_rand) ack_dly = $urandom_range(0, 5);
                end
                chk("wb_stb", 64'(bus.wb_stb_o), 64'(1));
                chk("wb_rsp_overlap", 64'(bus.rsp_valid), 64'(0));
                if (cmd_q.size() == 0) begin
                    fail("wb_unexpected_cycle", "got cyc=1 with no queued command, expected cyc=0");
                end else begin
                    sh = cmd_q[0];
                    chk("wb_fields", 64'({bus.wb_we_o, bus.wb_addr_o, bus.wb_sel_o, bus.wb_dat_o}),
                        64'({sh.we, sh.addr, sh.sel, sh.wdata}));
                    if (!ack_hold && req_cnt >= ack_dly) begin
                        d = slv_rand ? $urandom : slv_data;
                        bus.wb_ack_i = 1'b1;
                        bus.wb_dat_i = d;
                        exp_q.push_back('{sh.we, sh.we ? 32'h0 : d, 1'b0});
                        void'(cmd_q.pop_front());
                        last_width = req_cnt + 1;
                        ending = 1'b1;
                    end
`ifdef WBM_TIMEOUT_EN
                    else if (req_cnt == TMO - 1) begin
                        exp_q.push_back('{sh.we, 32'h0, 1'b1});
                        void'(cmd_q.pop_front());
                        last_width = TMO;
                        ending = 1'b1;
                    end
`endif
                end
                req_cnt++;
            end else begin
                if (inflight) begin
                    chk("wb_cyc_held", 64'(bus.wb_cyc_o), 64'(1));
                    inflight = 1'b0;
                end
                chk("wb_idle_dat", 64'(bus.wb_dat_o), 64'(0));
                if (stray_en && $urandom_range(0, 3) == 0) bus.wb_ack_i = 1'b1;
            end
        end
    end

    // Response consumer: compares each new response with the scoreboard, then checks it stays put.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_seen = 1'b0;
                continue;
            end
            if (bus.rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    cur_rsp  = '{bus.rsp_we, bus.rsp_rdata, bus.rsp_err};
                    last_rsp = cur_rsp;
                    if (exp_q.size() == 0) begin
                        fail("rsp_spurious", "got rsp_valid=1 with no outstanding command, expected 0");
                    end else begin
                        exp_r = exp_q.pop_front();
                        chk("rsp_fields", 64'({cur_rsp.we, cur_rsp.rdata, cur_rsp.err}),
                            64'({exp_r.we, exp_r.rdata, exp_r.err}));
                    end
                end else begin
                    chk("rsp_stable", 64'({bus.rsp_we, bus.rsp_rdata, bus.rsp_err}),
                        64'({cur_rsp.we, cur_rsp.rdata, cur_rsp.err}));
                end
            end
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_seen = 1'b0;
                n_rsp++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    vec_t vt[5];

    initial begin
        int base, n, seen0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_sel   = '0;
        bus.cmd_wdata = '0;

        vt[0] = '{'{1'b1, 5'h03, 4'h1, 32'h0000_0083}, 2, 32'hDEAD_BEEF, 32'h0,         3};
        vt[1] = '{'{1'b0, 5'h00, 4'h1, 32'h0000_0000}, 0, 32'h0000_005A, 32'h0000_005A, 1};
        vt[2] = '{'{1'b0, 5'h1F, 4'hF, 32'hFFFF_FFFF}, 1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 2};
        vt[3] = '{'{1'b1, 5'h1F, 4'hF, 32'hFFFF_FFFF}, 0, 32'h0000_1234, 32'h0,         1};
        vt[4] = '{'{1'b0, 5'h01, 4'h2, 32'h0000_0001}, 5, 32'h8000_0001, 32'h8000_0001, 6};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_sel_o}), 64'(0));
        chk("rst_wb_dat", 64'(bus.wb_dat_o), 64'(0));
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata}), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed table: one command at a time, checking latency, pulse width and read data.
        for (int i = 0; i < 5; i++) begin
            ack_dly  = vt[i].dly;
            slv_data = vt[i].sdata;
            push(vt[i].c);
            chk("lat_push_edge", 64'(bus.wb_cyc_o), 64'(0));
            @(posedge clk); #1;
            chk("lat_next_edge", 64'(bus.wb_cyc_o), 64'(1));
            wait_rsp(i + 1, 200, "tbl_rsp_count");
            @(posedge clk); #1;
            chk("tbl_rdata", 64'(last_rsp.rdata), 64'(vt[i].exp_rdata));
            chk("tbl_width", 64'(last_width), 64'(vt[i].exp_width));
        end

        // Five back-to-back pushes while the first command is stalled in its cycle.
        base = n_rsp;
        ack_hold = 1'b1;
        ack_dly  = 0;
        for (int i = 0; i < 5; i++) push(rand_cmd());
        chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("bp_cyc", 64'(bus.wb_cyc_o), 64'(1));
        slv_rand = 1'b1;
        ack_hold = 1'b0;
        rdy_mode = 1;
        wait_rsp(base + 5, 600, "bp_rsp_count");
        slv_rand = 1'b0;

        // Response back-pressure with a second command waiting.
        rdy_mode = 2;
        ack_dly  = 1;
        base = n_rsp;
        push(rand_cmd());
        push(rand_cmd());
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        repeat (10) begin
            @(posedge clk); #1;
            chk("hold_no_cyc", 64'(bus.wb_cyc_o), 64'(0));
            chk("hold_busy", 64'(bus.busy), 64'(1));
        end
        rdy_mode = 0;
        wait_rsp(base + 2, 200, "hold_rsp_count");

`ifdef WBM_TIMEOUT_EN
        // No ack at all, then ack exactly on the expiry edge.
        base = n_rsp;
        ack_hold = 1'b1;
        push('{1'b0, 5'h05, 4'h1, 32'h0});
        wait_rsp(base + 1, 200, "tmo_rsp_count");
        chk("tmo_err", 64'(last_rsp.err), 64'(1));
        chk("tmo_rdata", 64'(last_rsp.rdata), 64'(0));
        chk("tmo_width", 64'(last_width), 64'(TMO));
        ack_hold = 1'b0;
        ack_dly  = TMO - 1;
        slv_data = 32'h0000_0077;
        push('{1'b0, 5'h05, 4'h1, 32'h0});
        wait_rsp(base + 2, 200, "tmo_ack_rsp_count");
        chk("tmo_ack_err", 64'(last_rsp.err), 64'(0));
        chk("tmo_ack_rdata", 64'(last_rsp.rdata), 64'(32'h77));
        chk("tmo_ack_width", 64'(last_width), 64'(TMO));
        ack_dly = 0;
`endif

        // Reset in the middle of a cycle with two commands still queued.
        ack_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(rand_cmd());
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_cyc", 64'({bus.wb_cyc_o, bus.wb_stb_o}), 64'(0));
        chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_mid_busy", 64'(bus.busy), 64'(0));
        repeat (2) @(negedge clk);
        cmd_q.delete();
        exp_q.delete();
        rst = 1'b0;
        ack_hold = 1'b0;
        base  = n_rsp;
        seen0 = cyc_seen;
        repeat (20) @(posedge clk);
        chk("rst_no_cyc_after", 64'(cyc_seen), 64'(seen0));
        chk("rst_no_rsp_after", 64'(n_rsp), 64'(base));

        // Random traffic: random gaps, ack delays, read data, rsp_ready and stray acks.
        slv_rand = 1'b1;
        stray_en = 1'b1;
        rdy_mode = 1;
        base = n_rsp;
        for (int i = 0; i < 60; i++) begin
            push(rand_cmd());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_rsp(base + 60, 3000, "rand_rsp_count");
        stray_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("end_cmd_q_empty", 64'(cmd_q.size()), 64'(0));
        chk("end_exp_q_empty", 64'(exp_q.size()), 64'(0));
        chk("end_busy", 64'(bus.busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
